// File: rtl/apix_pkg.sv
// Shared defaults for the APIX serial pixel receiver.
// Frame length assumes the CRC checking build (APIX_CRC_EN defined).
package apix_pkg;

    localparam int         APIX_DATA_W   = 24;
    localparam int         APIX_CRC_W    = 8;
    localparam logic [7:0] APIX_CRC_POLY = 8'h07;
    localparam logic [7:0] APIX_CRC_INIT = 8'h00;
    localparam int         FRAME_LEN     = APIX_DATA_W + APIX_CRC_W;

endpackage

// File: rtl/apix_crc8_step.sv
// Combinational single-bit CRC update, MSB-first, implicit top term.
module apix_crc8_step
    import apix_pkg::*;
#(
    parameter int                CRC_W    = APIX_CRC_W,
    parameter logic [CRC_W-1:0]  CRC_POLY = APIX_CRC_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc_out
);

    logic fb_s;

    // Shift one bit through the generator polynomial.
    always_comb begin
        fb_s = crc_in[CRC_W-1] ^ data_bit;
        if (fb_s) begin
            crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ CRC_POLY;
        end else begin
            crc_out = {crc_in[CRC_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/apix_receiver.sv
// APIX serial pixel receiver: oversampled link clock/data, positional framing.
// Optional CRC checking is compiled in with the APIX_CRC_EN macro.
module apix_receiver
    import apix_pkg::*;
#(
    parameter int               DATA_W   = APIX_DATA_W,
    parameter int               CRC_W    = APIX_CRC_W,
    parameter logic [CRC_W-1:0] CRC_POLY = APIX_CRC_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT = APIX_CRC_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apix_data,
    input  logic              apix_clk,
    output logic [DATA_W-1:0] pixel_data,
    output logic              error_flag
);

`ifdef APIX_CRC_EN
    localparam int FRAME_BITS = DATA_W + CRC_W;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int             CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [1:0]        clk_sync_r;
    logic [1:0]        data_sync_r;
    logic              clk_prev_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] data_sr_r;
    logic              done_r;
    logic              bit_valid_s;
    logic              sample_bit_s;

`ifdef APIX_CRC_EN
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W);

    logic [CRC_W-1:0] crc_calc;
    logic [CRC_W-1:0] crc_rx_r;
    logic [CRC_W-1:0] crc_next_s;

    apix_crc8_step #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc_step (
        .crc_in   (crc_calc),
        .data_bit (sample_bit_s),
        .crc_out  (crc_next_s)
    );
`endif

    // Rising edge of the synchronized link clock marks a valid bit.
    always_comb begin
        bit_valid_s  = clk_sync_r[1] & ~clk_prev_r;
        sample_bit_s = data_sync_r[1];
    end

    // Synchronizers, framing counter, shift registers and frame evaluation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_r  <= 2'b00;
            data_sync_r <= 2'b00;
            clk_prev_r  <= 1'b0;
            cnt_r       <= '0;
            data_sr_r   <= '0;
            done_r      <= 1'b0;
            pixel_data  <= '0;
            error_flag  <= 1'b0;
`ifdef APIX_CRC_EN
            crc_calc    <= CRC_INIT;
            crc_rx_r    <= '0;
`endif
        end else begin
            clk_sync_r  <= {clk_sync_r[0], apix_clk};
            data_sync_r <= {data_sync_r[0], apix_data};
            clk_prev_r  <= clk_sync_r[1];
            done_r      <= 1'b0;

            // Evaluate the completed frame, then return to frame start.
            if (done_r) begin
`ifdef APIX_CRC_EN
                if (crc_rx_r == crc_calc) begin
                    pixel_data <= data_sr_r;
                    error_flag <= 1'b0;
                end else begin
                    error_flag <= 1'b1;
                end
                crc_calc <= CRC_INIT;
                crc_rx_r <= '0;
`else
                pixel_data <= data_sr_r;
`endif
                data_sr_r <= '0;
            end

            if (bit_valid_s) begin
`ifdef APIX_CRC_EN
                if (cnt_r < DATA_END) begin
                    data_sr_r <= {data_sr_r[DATA_W-2:0], sample_bit_s};
                    crc_calc  <= crc_next_s;
                end else begin
                    crc_rx_r  <= {crc_rx_r[CRC_W-2:0], sample_bit_s};
                end
`else
                data_sr_r <= {data_sr_r[DATA_W-2:0], sample_bit_s};
`endif
                if (cnt_r == LAST_BIT) begin
                    cnt_r  <= '0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r  <= cnt_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apix_receiver.sv
// Directed bench for apix_receiver; covers both the CRC and plain builds.
module tb_apix_receiver;

    logic        clk;
    logic        rst_n;
    logic        apix_data;
    logic        apix_clk;
    logic [23:0] pixel_data;
    logic        error_flag;

    int checks;
    int errors;

    apix_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apix_data  (apix_data),
        .apix_clk   (apix_clk),
        .pixel_data (pixel_data),
        .error_flag (error_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bits go out MSB first; data changes with apix_clk low, rises 10 ns later.
    task automatic send_bits(input logic [31:0] val, input int n);
        @(negedge clk);
        #2;
        for (int i = n - 1; i >= 0; i--) begin
            apix_clk  = 1'b0;
            apix_data = val[i];
            #10;
            apix_clk  = 1'b1;
            #10;
        end
    endtask

    task automatic send_frame(input logic [23:0] d, input logic [7:0] c);
        send_bits({8'h00, d}, 24);
`ifdef APIX_CRC_EN
        send_bits({24'h000000, c}, 8);
`else
        if (c === 8'hxx) begin
            apix_data = 1'b0;
        end
`endif
    endtask

    task automatic wait_eval();
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] crc_ref(input logic [23:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    initial begin
        logic [7:0] ref_crc;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        apix_clk  = 1'b0;
        apix_data = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_pixel", {8'h00, pixel_data}, 32'h00000000);
        check("reset_err", {31'h0, error_flag}, 32'h00000000);
`ifdef APIX_CRC_EN
        check("reset_crc", {24'h0, dut.crc_calc}, 32'h00000000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

`ifdef APIX_CRC_EN
        send_frame(24'h000000, 8'h00);
        wait_eval();
        check("zero_err", {31'h0, error_flag}, 32'h00000000);
        check("zero_pixel", {8'h00, pixel_data}, 32'h00000000);

        send_frame(24'h123456, 8'hFF);
        wait_eval();
        check("badcrc_err", {31'h0, error_flag}, 32'h00000001);
        check("badcrc_pixel", {8'h00, pixel_data}, 32'h00000000);

        ref_crc = crc_ref(24'h789ABC);
        send_bits(32'h00789ABC, 24);
        repeat (3) @(posedge clk);
        #1;
        check("crc_calc_ref", {24'h0, dut.crc_calc}, {24'h0, ref_crc});
        send_bits({24'h0, ref_crc}, 8);
        wait_eval();
        check("good_err", {31'h0, error_flag}, 32'h00000000);
        check("good_pixel", {8'h00, pixel_data}, 32'h00789ABC);

        send_frame(24'h111111, crc_ref(24'h111111) ^ 8'h01);
        wait_eval();
        check("hold_err", {31'h0, error_flag}, 32'h00000001);
        check("hold_pixel", {8'h00, pixel_data}, 32'h00789ABC);

        send_frame(24'hA5C3E1, crc_ref(24'hA5C3E1));
        wait_eval();
        check("good2_err", {31'h0, error_flag}, 32'h00000000);
        check("good2_pixel", {8'h00, pixel_data}, 32'h00A5C3E1);
`else
        send_frame(24'hFFAA55, 8'h00);
        wait_eval();
        check("plain_pixel", {8'h00, pixel_data}, 32'h00FFAA55);
        check("plain_err", {31'h0, error_flag}, 32'h00000000);

        send_frame(24'h123456, 8'h00);
        wait_eval();
        check("plain2_pixel", {8'h00, pixel_data}, 32'h00123456);
        check("plain2_err", {31'h0, error_flag}, 32'h00000000);

        send_frame(24'h789ABC, 8'h00);
        wait_eval();
        check("plain3_pixel", {8'h00, pixel_data}, 32'h00789ABC);

        send_frame(24'hA5C3E1, 8'h00);
        wait_eval();
        check("plain4_pixel", {8'h00, pixel_data}, 32'h00A5C3E1);
        check("plain4_err", {31'h0, error_flag}, 32'h00000000);
`endif

        // Ten bits of a frame, then reset with link activity during reset.
        send_bits(32'h00FFAA55 >> 14, 10);
        @(negedge clk);
        rst_n = 1'b0;
        send_bits(32'h00000003, 2);
        apix_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_pixel", {8'h00, pixel_data}, 32'h00000000);
        check("midrst_err", {31'h0, error_flag}, 32'h00000000);
`ifdef APIX_CRC_EN
        check("midrst_crc", {24'h0, dut.crc_calc}, 32'h00000000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        send_frame(24'h00FF00, crc_ref(24'h00FF00));
        wait_eval();
        check("after_rst_pixel", {8'h00, pixel_data}, 32'h0000FF00);
        check("after_rst_err", {31'h0, error_flag}, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apix_receiver.md
APIX_RECEIVER -- requirements
Module: apix_receiver

Interface
REQ-001 Parameter DATA_W, default 24, pixel payload width in bits.
REQ-002 Parameter CRC_W, default 8, CRC field width in bits.
REQ-003 Parameter CRC_POLY, default 8'h07, CRC-8 generator polynomial with implicit x^8 term.
REQ-004 Parameter CRC_INIT, default 8'h00, CRC register value at the start of each frame.
REQ-005 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 Port apix_data, input, 1, serial link data, MSB first; asynchronous to clk.
REQ-008 Port apix_clk, input, 1, link bit clock; asynchronous to clk and sampled as data, never used as a clock.
REQ-009 Port pixel_data, output, DATA_W, last pixel accepted, registered.
REQ-010 Port error_flag, output, 1, CRC mismatch status of the most recent frame, registered.

Function
REQ-011 apix_clk and apix_data each pass through a 2-flop synchronizer in the clk domain.
REQ-012 A link bit is sampled in the clk cycle where synchronized apix_clk shows a rising edge (previous value 0, current value 1).
- apix_clk must be at most clk/2 for correct sampling.
REQ-013 A frame is DATA_W data bits followed by CRC_W CRC bits, 32 bits by default, with no gaps or delimiters.
- Framing is positional: a bit counter runs from 0 to DATA_W+CRC_W-1 and wraps to 0 after the last bit.
REQ-014 Data bits shift MSB-first into a DATA_W shift register.
REQ-015 CRC bits shift MSB-first into a CRC_W shift register.
REQ-016 Internal register crc_calc[7:0] holds the running CRC and must keep exactly this name, because benches probe it hierarchically.
- Loaded with CRC_INIT at frame start.
- Updated serially for each data bit: fb = crc_calc[7] ^ bit; crc_calc = {crc_calc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
- Held constant during the CRC bits.
REQ-017 One clk cycle after the last CRC bit is sampled, the frame is evaluated.
- pixel_data loads the received data only when the received CRC equals crc_calc; otherwise pixel_data holds its previous value.
- error_flag is set to 1 on a mismatch and cleared to 0 on a match.
- Both outputs then hold until the next frame evaluation.
REQ-018 The bit counter, shift registers and crc_calc reset to frame start on wrap, so the next frame begins on the next sampled bit.
REQ-019 apix_clk edges while rst_n is low are ignored.

Reset
REQ-020 When rst_n is 0 at a clk edge: pixel_data=0, error_flag=0, crc_calc=CRC_INIT, bit counter=0, shift registers=0, synchronizers=0.
REQ-021 A reset asserted mid-frame discards the partial frame.
- The first bit sampled after reset deasserts is bit 0 of a new frame.

Configuration
REQ-022 Macro APIX_CRC_EN, when defined, compiles in CRC checking as described in REQ-013 to REQ-018.
REQ-023 When APIX_CRC_EN is not defined:
- A frame is DATA_W bits only.
- pixel_data loads unconditionally at every frame end.
- error_flag is tied to 0.
- crc_calc and the CRC shift register are absent.

Structure
REQ-024 Package apix_pkg holds the DATA_W/CRC_W/CRC_POLY/CRC_INIT defaults and a frame-length constant FRAME_LEN = DATA_W+CRC_W.
REQ-025 Sub-module apix_crc8_step implements the combinational one-bit CRC update (inputs crc_in and bit, output crc_out) and is instantiated once.

Verification (APIX_CRC_EN defined, clk 100 MHz, apix_clk 50 MHz, data changed on apix_clk falling edges)
REQ-026 Reset for 5 clk cycles -> pixel_data=24'h000000, error_flag=0, crc_calc=8'h00.
REQ-027 Send frame 24'h000000 + CRC 8'h00 -> error_flag=0 and pixel_data=24'h000000 one clk after the last bit.
REQ-028 Send 24'h123456 + CRC 8'hFF (incorrect) -> error_flag=1; pixel_data keeps its prior value.
REQ-029 Send 24'h789ABC + the value of crc_calc after the data bits -> error_flag=0, pixel_data=24'h789ABC.
- The bench must also compare crc_calc against a reference CRC-8 (polynomial 0x07, init 0x00) computed over the data.
REQ-030 Assert rst_n low after 10 bits of 24'hFFAA55 -> outputs clear.
- A full correct frame 24'h00FF00 sent after release is then accepted, with pixel_data=24'h00FF00 and error_flag=0.
REQ-031 APIX_CRC_EN undefined: send 24'hFFAA55 -> pixel_data=24'hFFAA55 after 24 bits; error_flag stays 0.
